cpu_out_capture: RTL and testbench

- Sits directly downstream of the multicycle CPU and consumes its 32-bit Out bus.
- Captures each new Out value (on a change, or on an explicit strobe) into a synchronous FIFO.
- Presents captured words on a valid/ready drain interface for a display, UART or bench scoreboard.
- Decouples CPU execution speed from the consumer; loses no data until the FIFO is full.

---
 rtl/cpu_out_pkg.sv | 12 +
 rtl/cpu_out_capture_if.sv | 37 +++
 rtl/sync_fifo_mem.sv | 30 +++
 rtl/cpu_out_capture.sv | 113 +++++++++++
 tb/tb_cpu_out_capture.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_out_pkg.sv
// Shared constants and helpers for the CPU Out capture FIFO.
package cpu_out_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DROP_CNT_W     = 16;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/cpu_out_capture_if.sv
// Capture-side and drain-side signals of cpu_out_capture; DropCount exists only with CPU_OUT_DROP_COUNT_EN.
interface cpu_out_capture_if #(
   parameter int DATA_W = cpu_out_pkg::DEFAULT_DATA_W,
   parameter int DEPTH  = 8
);
   import cpu_out_pkg::*;

   logic [DATA_W-1:0]       CpuOut;
   logic                    CpuOutStrobe;
   logic [DATA_W-1:0]       DrainData;
   logic                    DrainValid;
   logic                    DrainReady;
   logic [ptr_w(DEPTH)-1:0] Count;
   logic                    Full;
   logic                    Empty;
   logic                    Overflow;
`ifdef CPU_OUT_DROP_COUNT_EN
   logic [DROP_CNT_W-1:0]   DropCount;
`endif

   modport master (
      output CpuOut, CpuOutStrobe, DrainReady,
`ifdef CPU_OUT_DROP_COUNT_EN
      input  DropCount,
`endif
      input  DrainData, DrainValid, Count, Full, Empty, Overflow
   );

   modport slave (
      input  CpuOut, CpuOutStrobe, DrainReady,
`ifdef CPU_OUT_DROP_COUNT_EN
      output DropCount,
`endif
      output DrainData, DrainValid, Count, Full, Empty, Overflow
   );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: registered write port, asynchronous read port.
module sync_fifo_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_out_capture.sv
// Captures changes (or strobes) of the CPU Out bus into a first-word fall-through FIFO.
// Optional sticky drop counter is enabled by defining CPU_OUT_DROP_COUNT_EN.
module cpu_out_capture #(
   parameter int DATA_W      = cpu_out_pkg::DEFAULT_DATA_W,
   parameter int DEPTH       = 8,
   parameter bit CHANGE_ONLY = 1'b1
) (
   input logic              Clk,
   input logic              Reset,
   cpu_out_capture_if.slave bus
);
   import cpu_out_pkg::*;

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] last_out_q, last_out_d;
   logic              overflow_q, overflow_d;

   logic              empty, full;
   logic              push_req, pop, push_ok, drop;
   logic [DATA_W-1:0] rdata;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      push_req = bus.CpuOutStrobe || (CHANGE_ONLY && (bus.CpuOut != last_out_q));
      pop      = !empty && bus.DrainReady;
      push_ok  = push_req && (!full || pop);
      drop     = push_req && full && !pop;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      last_out_d = bus.CpuOut;
      overflow_d = overflow_q || drop;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         last_out_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         last_out_q <= last_out_d;
         overflow_q <= overflow_d;
      end
   end

   sync_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (Clk),
      .we    (push_ok && !Reset),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (bus.CpuOut),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (rdata)
   );

   assign bus.DrainData  = rdata;
   assign bus.DrainValid = !empty;
   assign bus.Count      = count_q;
   assign bus.Full       = full;
   assign bus.Empty      = empty;
   assign bus.Overflow   = overflow_q;

`ifdef CPU_OUT_DROP_COUNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Saturates rather than wrapping so a long overload never reads as "few drops".
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.DropCount = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_out_capture.sv
// Self-checking bench for cpu_out_capture: a change-capture instance (A) and a strobe-only instance (B).
module tb_cpu_out_capture;
   import cpu_out_pkg::*;

   localparam int DEPTH = 8;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   cpu_out_capture_if #(.DATA_W(32), .DEPTH(DEPTH)) ifA ();
   cpu_out_capture_if #(.DATA_W(32), .DEPTH(DEPTH)) ifB ();

   cpu_out_capture #(.DATA_W(32), .DEPTH(DEPTH), .CHANGE_ONLY(1'b1)) dutA (
      .Clk(Clk), .Reset(Reset), .bus(ifA));
   cpu_out_capture #(.DATA_W(32), .DEPTH(DEPTH), .CHANGE_ONLY(1'b0)) dutB (
      .Clk(Clk), .Reset(Reset), .bus(ifB));

   int nCompared = 0;
   int nMismatched = 0;

   // Reference model: the FIFO as a plain queue per instance.
   typedef logic [31:0] wordQ_t[$];
   wordQ_t      mq [2];
   logic [31:0] mLast [2];
   bit          mOvf [2];
   int          mDrop [2];

   task automatic tick();
      logic [31:0] cpu;
      bit stb, rdy, push;
      for (int k = 0; k < 2; k++) begin
         cpu = (k == 0) ? ifA.CpuOut : ifB.CpuOut;
         stb = (k == 0) ? ifA.CpuOutStrobe : ifB.CpuOutStrobe;
         rdy = (k == 0) ? ifA.DrainReady : ifB.DrainReady;
         if (Reset) begin
            mq[k].delete();
            mLast[k] = '0;
            mOvf[k]  = 1'b0;
            mDrop[k] = 0;
         end else begin
            push = stb || (k == 0 && cpu != mLast[k]);
            if (mq[k].size() > 0 && rdy) void'(mq[k].pop_front());
            if (push) begin
               if (mq[k].size() < DEPTH) mq[k].push_back(cpu);
               else begin
                  mOvf[k] = 1'b1;
                  if (mDrop[k] < 65535) mDrop[k]++;
               end
            end
            mLast[k] = cpu;
         end
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) tick();
      nCompared++;
      if ({ifA.Empty, ifA.DrainValid, ifA.Full, ifA.Overflow, ifA.Count} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
         nMismatched++;
         $display("[TB] FAIL reset_state: got E/V/F/O/C=%b%b%b%b/%0d expected 1000/0", ifA.Empty, ifA.DrainValid, ifA.Full, ifA.Overflow, ifA.Count);
      end
      Reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         nCompared++;
         if ({ifA.Empty, ifA.DrainValid, ifA.Count} !== {1'b1, 1'b0, 4'd0}) begin
            nMismatched++;
            $display("[TB] FAIL idle_no_push: cycle %0d got E/V/C=%b%b/%0d expected 10/0", i, ifA.Empty, ifA.DrainValid, ifA.Count);
         end
      end
   endtask

   task automatic test_change_stream();
      logic [31:0] vals [5];
      logic [31:0] want [3];
      wordQ_t got;
      vals = '{32'h0, 32'h5, 32'h5, 32'h9, 32'hDEADBEEF};
      want = '{32'h5, 32'h9, 32'hDEADBEEF};
      ifA.DrainReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i < 5) ifA.CpuOut = vals[i];
         tick();
         if (ifA.DrainValid === 1'b1) got.push_back(ifA.DrainData);
         nCompared++;
         if (ifA.DrainValid !== (mq[0].size() != 0) || (mq[0].size() != 0 && ifA.DrainData !== mq[0][0])) begin
            nMismatched++;
            $display("[TB] FAIL stream_head: step %0d got v=%b d=%0h expected v=%b", i, ifA.DrainValid, ifA.DrainData, mq[0].size() != 0);
         end
      end
      nCompared++;
      if (got.size() != 3 || got[0] !== want[0] || got[1] !== want[1] || got[2] !== want[2]) begin
         nMismatched++;
         $display("[TB] FAIL stream_sequence: got %0d words expected 5,9,deadbeef", got.size());
      end
      nCompared++;
      if (ifA.Count !== 4'd0) begin
         nMismatched++;
         $display("[TB] FAIL stream_count: got %0d expected 0", ifA.Count);
      end
   endtask

   task automatic test_overflow();
      ifA.DrainReady = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         ifA.CpuOut = 32'(i);
         tick();
         nCompared++;
         if ({ifA.Full, ifA.Overflow, ifA.Count} !== {i >= 8, i >= 9, 4'((i > 8) ? 8 : i)}) begin
            nMismatched++;
            $display("[TB] FAIL fill_flags: change %0d got F/O/C=%b%b/%0d", i, ifA.Full, ifA.Overflow, ifA.Count);
         end
      end
      nCompared++;
      if (ifA.DrainData !== 32'h1) begin
         nMismatched++;
         $display("[TB] FAIL full_head: got %0h expected 1", ifA.DrainData);
      end
`ifdef CPU_OUT_DROP_COUNT_EN
      nCompared++;
      if (ifA.DropCount !== 16'd2) begin
         nMismatched++;
         $display("[TB] FAIL drop_count: got %0d expected 2", ifA.DropCount);
      end
`endif
   endtask

   task automatic test_full_push_pop();
      wordQ_t got;
      ifA.DrainReady = 1'b1;
      ifA.CpuOut = 32'h77;
      tick();
      nCompared++;
      if ({ifA.Full, ifA.Overflow, ifA.Count, ifA.DrainData} !== {1'b1, 1'b1, 4'd8, 32'h2}) begin
         nMismatched++;
         $display("[TB] FAIL full_push_pop: got F/O/C/D=%b%b/%0d/%0h expected 11/8/2", ifA.Full, ifA.Overflow, ifA.Count, ifA.DrainData);
      end
      for (int n = 0; n < 20 && ifA.DrainValid === 1'b1; n++) begin
         got.push_back(ifA.DrainData);
         tick();
      end
      nCompared++;
      if (got.size() != 8) begin
         nMismatched++;
         $display("[TB] FAIL drain_len: got %0d expected 8", got.size());
      end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         nCompared++;
         if (got[i] !== ((i == 7) ? 32'h77 : 32'(i + 2))) begin
            nMismatched++;
            $display("[TB] FAIL drain_word: index %0d got %0h expected %0h", i, got[i], (i == 7) ? 32'h77 : 32'(i + 2));
         end
      end
   endtask

   task automatic test_strobe();
      ifB.DrainReady = 1'b0;
      ifB.CpuOut = 32'h12;
      tick();
      repeat (3) begin
         ifB.CpuOutStrobe = 1'b1;
         tick();
         ifB.CpuOutStrobe = 1'b0;
         tick();
      end
      ifB.CpuOut = 32'h34;
      tick();
      ifB.CpuOut = 32'h56;
      tick();
      nCompared++;
      if (ifB.Count !== 4'd3) begin
         nMismatched++;
         $display("[TB] FAIL strobe_count: got %0d expected 3", ifB.Count);
      end
      ifB.DrainReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         nCompared++;
         if (ifB.DrainValid !== 1'b1 || ifB.DrainData !== 32'h12) begin
            nMismatched++;
            $display("[TB] FAIL strobe_word: index %0d got v=%b d=%0h expected 1/12", i, ifB.DrainValid, ifB.DrainData);
         end
         tick();
      end
      nCompared++;
      if (ifB.Empty !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL strobe_empty: got %b expected 1", ifB.Empty);
      end
      ifB.DrainReady = 1'b0;
      // Strobe coinciding with a change must yield exactly one push.
      ifA.DrainReady = 1'b0;
      ifA.CpuOut = 32'hA5;
      ifA.CpuOutStrobe = 1'b1;
      tick();
      ifA.CpuOutStrobe = 1'b0;
      nCompared++;
      if ({ifA.Count, ifA.DrainData} !== {4'd1, 32'hA5}) begin
         nMismatched++;
         $display("[TB] FAIL strobe_plus_change: got C/D=%0d/%0h expected 1/a5", ifA.Count, ifA.DrainData);
      end
      ifA.DrainReady = 1'b1;
      tick();
      ifA.CpuOut = 32'hB6;
      tick();
      nCompared++;
      if ({ifA.Count, ifA.DrainValid, ifA.DrainData} !== {4'd1, 1'b1, 32'hB6}) begin
         nMismatched++;
         $display("[TB] FAIL empty_push_ready: got C/V/D=%0d/%b/%0h expected 1/1/b6", ifA.Count, ifA.DrainValid, ifA.DrainData);
      end
      tick();
      ifA.DrainReady = 1'b0;
   endtask

   task automatic test_reset_midstream();
      ifA.DrainReady = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         ifA.CpuOut = 32'h100 + 32'(i);
         tick();
      end
      nCompared++;
      if (ifA.Count !== 4'd4) begin
         nMismatched++;
         $display("[TB] FAIL pre_reset_count: got %0d expected 4", ifA.Count);
      end
      Reset = 1'b1;
      ifA.CpuOut = 32'hAA;
      ifA.CpuOutStrobe = 1'b1;
      tick();
      Reset = 1'b0;
      ifA.CpuOutStrobe = 1'b0;
      ifA.CpuOut = 32'h0;
      nCompared++;
      if ({ifA.Count, ifA.Empty, ifA.Overflow} !== {4'd0, 1'b1, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL midstream_reset: got C/E/O=%0d/%b%b expected 0/10", ifA.Count, ifA.Empty, ifA.Overflow);
      end
`ifdef CPU_OUT_DROP_COUNT_EN
      nCompared++;
      if (ifA.DropCount !== 16'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_drop_count: got %0d expected 0", ifA.DropCount);
      end
`endif
      tick();
      ifA.CpuOut = 32'h5A;
      tick();
      nCompared++;
      if ({ifA.Count, ifA.DrainValid, ifA.DrainData} !== {4'd1, 1'b1, 32'h5A}) begin
         nMismatched++;
         $display("[TB] FAIL first_after_reset: got C/V/D=%0d/%b/%0h expected 1/1/5a", ifA.Count, ifA.DrainValid, ifA.DrainData);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         ifA.CpuOut       = $urandom_range(0, 3);
         ifA.CpuOutStrobe = ($urandom_range(0, 3) == 0);
         ifA.DrainReady   = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         ifB.CpuOut       = $urandom;
         ifB.CpuOutStrobe = ($urandom_range(0, 1) == 0);
         ifB.DrainReady   = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         Reset            = ($urandom_range(0, 99) == 0);
         tick();
         nCompared++;
         if ({ifA.Count, ifA.Full, ifA.Empty, ifA.DrainValid, ifA.Overflow} !==
             {4'(mq[0].size()), mq[0].size() == DEPTH, mq[0].size() == 0, mq[0].size() != 0, mOvf[0]} ||
             (mq[0].size() != 0 && ifA.DrainData !== mq[0][0])) begin
            nMismatched++;
            $display("[TB] FAIL random_A: cycle %0d got C=%0d O=%b D=%0h expected C=%0d O=%b", i, ifA.Count, ifA.Overflow, ifA.DrainData, mq[0].size(), mOvf[0]);
         end
         nCompared++;
         if ({ifB.Count, ifB.Full, ifB.Empty, ifB.DrainValid, ifB.Overflow} !==
             {4'(mq[1].size()), mq[1].size() == DEPTH, mq[1].size() == 0, mq[1].size() != 0, mOvf[1]} ||
             (mq[1].size() != 0 && ifB.DrainData !== mq[1][0])) begin
            nMismatched++;
            $display("[TB] FAIL random_B: cycle %0d got C=%0d O=%b D=%0h expected C=%0d O=%b", i, ifB.Count, ifB.Overflow, ifB.DrainData, mq[1].size(), mOvf[1]);
         end
`ifdef CPU_OUT_DROP_COUNT_EN
         nCompared++;
         if (ifA.DropCount !== 16'(mDrop[0]) || ifB.DropCount !== 16'(mDrop[1])) begin
            nMismatched++;
            $display("[TB] FAIL random_drops: cycle %0d got %0d/%0d expected %0d/%0d", i, ifA.DropCount, ifB.DropCount, mDrop[0], mDrop[1]);
         end
`endif
      end
      Reset = 1'b0;
   endtask

   initial begin
      ifA.CpuOut = '0;
      ifA.CpuOutStrobe = 1'b0;
      ifA.DrainReady = 1'b0;
      ifB.CpuOut = '0;
      ifB.CpuOutStrobe = 1'b0;
      ifB.DrainReady = 1'b0;
      #1;
      test_reset();
      test_change_stream();
      test_overflow();
      test_full_push_pop();
      test_strobe();
      test_reset_midstream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
